// File: rtl/ahbl_uart_rx_if.sv
// AHB-Lite slave-side bus bundle for the UART receiver peripheral slot.
// Clock and reset stay outside the bundle as plain module ports.
interface ahbl_uart_rx_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic        HWRITE;
   logic        HREADY;
   logic [31:0] HWDATA;
   logic        HREADYOUT;
   logic [31:0] HRDATA;

   modport master (
      output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA,
      input  HREADYOUT, HRDATA
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA,
      output HREADYOUT, HRDATA
   );
endinterface

// File: rtl/ahbl_uart_rx.sv
// AHB-Lite UART receiver: 16x oversampled 8N1 deframer feeding a small FIFO,
// exposed as DATA/STATUS/PRESCALE/CTRL registers with a level interrupt.
module ahbl_uart_rx #(
   parameter int FIFO_DEPTH   = 4,
   parameter int PRESCALE_RST = 26
) (
   input  logic           HCLK,
   input  logic           HRESETn,
   ahbl_uart_rx_if.slave  bus,
   input  logic           rx,
   output logic           irq
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   logic          r_valid, r_wr;
   logic [1:0]    r_addr;
   logic [15:0]   r_prescale;
   logic [1:0]    r_ctrl;
   logic          r_overrun, r_frame_err;
   logic          r_rx_s1, r_rx_s2, r_rx_d;
   logic [15:0]   r_tick_cnt;
   state_t        r_state;
   logic [3:0]    r_samp;
   logic [2:0]    r_bitcnt;
   logic [7:0]    r_shift;
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [AW:0]   r_count;

   logic w_addr_ph, w_wr_en, w_rd_en, w_empty, w_full, w_pop;
   logic w_fall, w_start, w_tick, w_stop_smp, w_push, w_ovr_set, w_fe_set;
   logic w_unused;

   assign w_addr_ph  = bus.HSEL & bus.HREADY & bus.HTRANS[1];
   assign w_wr_en    = r_valid & r_wr;
   assign w_rd_en    = r_valid & ~r_wr;
   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
   assign w_pop      = w_rd_en & (r_addr == 2'd0) & ~w_empty;
   assign w_fall     = r_rx_d & ~r_rx_s2;
   assign w_start    = (r_state == S_IDLE) & r_ctrl[0] & w_fall;
   assign w_tick     = (r_tick_cnt == '0);
   assign w_stop_smp = (r_state == S_STOP) & r_ctrl[0] & w_tick & (r_samp == 4'd15);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte
   assign w_push     = w_stop_smp & r_rx_s2 & (~w_full | w_pop);
   assign w_ovr_set  = w_stop_smp & r_rx_s2 & w_full & ~w_pop;
   assign w_fe_set   = w_stop_smp & ~r_rx_s2;

   assign bus.HREADYOUT = 1'b1;
   assign irq           = r_ctrl[1] & ~w_empty;
   assign w_unused      = &{1'b0, bus.HSIZE, bus.HADDR[31:4], bus.HADDR[1:0],
                            bus.HTRANS[0], bus.HWDATA[31:16]};

   always_comb begin
      bus.HRDATA = '0;
      if (w_rd_en) begin
         case (r_addr)
            2'd0:    bus.HRDATA[7:0]  = w_empty ? 8'h00 : r_mem[r_rptr];
            2'd1:    bus.HRDATA[3:0]  = {r_frame_err, r_overrun, w_full, ~w_empty};
            2'd2:    bus.HRDATA[15:0] = r_prescale;
            default: bus.HRDATA[1:0]  = r_ctrl;
         endcase
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_valid     <= 1'b0;
         r_wr        <= 1'b0;
         r_addr      <= '0;
         r_prescale  <= 16'(PRESCALE_RST);
         r_ctrl      <= 2'b01;
         r_overrun   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         if (bus.HREADY) begin
            r_valid <= w_addr_ph;
            r_wr    <= bus.HWRITE;
            r_addr  <= bus.HADDR[3:2];
         end
         if (w_wr_en && r_addr == 2'd2) r_prescale <= bus.HWDATA[15:0];
         if (w_wr_en && r_addr == 2'd3) r_ctrl     <= bus.HWDATA[1:0];
         if (w_ovr_set)
            r_overrun <= 1'b1;
         else if (w_wr_en && r_addr == 2'd1 && bus.HWDATA[2])
            r_overrun <= 1'b0;
         if (w_fe_set)
            r_frame_err <= 1'b1;
         else if (w_wr_en && r_addr == 2'd1 && bus.HWDATA[3])
            r_frame_err <= 1'b0;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_rx_s1    <= 1'b1;
         r_rx_s2    <= 1'b1;
         r_rx_d     <= 1'b1;
         r_tick_cnt <= '0;
      end else begin
         r_rx_s1 <= rx;
         r_rx_s2 <= r_rx_s1;
         r_rx_d  <= r_rx_s2;
         if (w_start || w_tick)
            r_tick_cnt <= r_prescale;
         else
            r_tick_cnt <= r_tick_cnt - 1'b1;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state  <= S_IDLE;
         r_samp   <= '0;
         r_bitcnt <= '0;
         r_shift  <= '0;
      end else if (!r_ctrl[0]) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: if (w_fall) begin
               r_samp  <= '0;
               r_state <= S_START;
            end
            S_START: if (w_tick) begin
               if (r_samp == 4'd7) begin
                  r_samp   <= '0;
                  r_bitcnt <= '0;
                  r_state  <= r_rx_s2 ? S_IDLE : S_DATA;
               end else begin
                  r_samp <= r_samp + 1'b1;
               end
            end
            S_DATA: if (w_tick) begin
               if (r_samp == 4'd15) begin
                  r_shift  <= {r_rx_s2, r_shift[7:1]};
                  r_samp   <= '0;
                  r_bitcnt <= r_bitcnt + 1'b1;
                  if (r_bitcnt == 3'd7) r_state <= S_STOP;
               end else begin
                  r_samp <= r_samp + 1'b1;
               end
            end
            default: if (w_tick) begin
               if (r_samp == 4'd15)
                  r_state <= S_IDLE;
               else
                  r_samp <= r_samp + 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge HCLK) begin
      if (w_push) r_mem[r_wptr] <= r_shift;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: tb/tb_ahbl_uart_rx.sv
// Bench for ahbl_uart_rx: a frame-level model predicts register reads, which are
// queued at issue time and checked by an independent monitor in the data phase.
module tb_ahbl_uart_rx;
   localparam int DEPTH   = 4;
   localparam int PRE_RST = 26;

   logic HCLK = 1'b0;
   logic HRESETn = 1'b0;
   logic rx = 1'b1;
   logic irq;

   ahbl_uart_rx_if bus_if();

   ahbl_uart_rx #(.FIFO_DEPTH(DEPTH), .PRESCALE_RST(PRE_RST)) dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .bus     (bus_if),
      .rx      (rx),
      .irq     (irq)
   );

   always #5 HCLK = ~HCLK;

   typedef struct { string name; logic [31:0] exp; } rd_exp_t;
   typedef struct { string name; int sel; logic [31:0] exp; } probe_t;

   rd_exp_t rd_q[$];
   probe_t  pr_q[$];
   int n_checks = 0;
   int n_errors = 0;
   logic dp_rd = 1'b0;

   // Model state: received bytes, sticky flags and register copies
   logic [7:0]  m_fifo[$];
   logic        m_ovr, m_fe;
   logic [1:0]  m_ctrl;
   logic [15:0] m_pre;

   always @(posedge HCLK)
      dp_rd <= bus_if.HSEL & bus_if.HREADY & bus_if.HTRANS[1] & ~bus_if.HWRITE & HRESETn;

   always @(negedge HCLK) begin : monitor
      rd_exp_t e;
      probe_t  p;
      logic [31:0] act;
      if (dp_rd) begin
         n_checks++;
         if (rd_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_read: got %h, required no read", bus_if.HRDATA);
         end else begin
            e = rd_q.pop_front();
            if (bus_if.HRDATA !== e.exp) begin
               n_errors++;
               $display("FAIL %s: got %h, required %h", e.name, bus_if.HRDATA, e.exp);
            end
         end
      end
      while (pr_q.size() > 0) begin
         p = pr_q.pop_front();
         case (p.sel)
            0:       act = {31'b0, irq};
            1:       act = bus_if.HRDATA;
            default: act = {31'b0, bus_if.HREADYOUT};
         endcase
         n_checks++;
         if (act !== p.exp) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", p.name, act, p.exp);
         end
      end
   end

   function automatic logic [31:0] m_status();
      return {28'b0, m_fe, m_ovr, (m_fifo.size() == DEPTH), (m_fifo.size() != 0)};
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(posedge HCLK);
      #1;
   endtask

   task automatic addr_phase(input logic [3:0] a, input logic w);
      bus_if.HSEL   = 1'b1;
      bus_if.HTRANS = 2'b10;
      bus_if.HADDR  = {28'h4000_300, a};
      bus_if.HWRITE = w;
      @(posedge HCLK);
      #1;
      bus_if.HSEL   = 1'b0;
      bus_if.HTRANS = 2'b00;
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string nm);
      rd_exp_t e;
      e.name = nm;
      e.exp  = exp;
      rd_q.push_back(e);
      addr_phase(a, 1'b0);
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      addr_phase(a, 1'b1);
      bus_if.HWDATA = d;
      cyc(1);
   endtask

   task automatic probe(input string nm, input int sel, input logic [31:0] exp);
      probe_t p;
      p.name = nm;
      p.sel  = sel;
      p.exp  = exp;
      pr_q.push_back(p);
   endtask

   task automatic rd_data(input string nm);
      logic [31:0] e;
      e = '0;
      if (m_fifo.size() > 0) e = {24'b0, m_fifo.pop_front()};
      rd(4'h0, e, nm);
   endtask

   task automatic rd_status(input string nm);
      rd(4'h4, m_status(), nm);
   endtask

   task automatic wr_status(input logic [31:0] d);
      wr(4'h4, d);
      if (d[2]) m_ovr = 1'b0;
      if (d[3]) m_fe  = 1'b0;
   endtask

   task automatic wr_pre(input logic [15:0] d);
      wr(4'h8, {16'b0, d});
      m_pre = d;
   endtask

   task automatic wr_ctrl(input logic [1:0] d);
      wr(4'hC, {30'b0, d});
      m_ctrl = d;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      int bp;
      bp = 16 * (int'(m_pre) + 1);
      rx = 1'b0;
      cyc(bp);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         cyc(bp);
      end
      rx = stop;
      cyc(bp);
      rx = 1'b1;
      cyc(4);
      if (m_ctrl[0]) begin
         if (!stop)                     m_fe = 1'b1;
         else if (m_fifo.size() < DEPTH) m_fifo.push_back(d);
         else                            m_ovr = 1'b1;
      end
   endtask

   task automatic model_reset();
      m_fifo.delete();
      m_ovr  = 1'b0;
      m_fe   = 1'b0;
      m_ctrl = 2'b01;
      m_pre  = 16'(PRE_RST);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [7:0] d;
      bus_if.HSEL   = 1'b0;
      bus_if.HADDR  = '0;
      bus_if.HTRANS = 2'b00;
      bus_if.HSIZE  = 3'b010;
      bus_if.HWRITE = 1'b0;
      bus_if.HREADY = 1'b1;
      bus_if.HWDATA = '0;
      model_reset();

      cyc(3);
      probe("rst_hrdata", 1, 32'h0);
      probe("rst_hreadyout", 2, 32'h1);
      probe("rst_irq", 0, 32'h0);
      cyc(1);
      HRESETn = 1'b1;
      cyc(2);
      rd_status("rst_status");
      rd(4'h8, 32'(PRE_RST), "rst_prescale");
      rd(4'hC, 32'h1, "rst_ctrl");
      rd_data("rst_data_empty");
      cyc(2);

      // Single byte, polled
      wr_pre(16'd0);
      send_frame(8'hA5, 1'b1);
      rd_status("t1_status");
      probe("t1_irq_off", 0, 32'h0);
      rd_data("t1_data");
      rd_status("t1_status_after");
      cyc(2);

      // Overrun: five bytes into a four-entry FIFO, then back-to-back drains
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
      rd_status("t2_status_full");
      for (int i = 0; i < 4; i++) rd_data("t2_drain");
      rd_status("t2_status_drained");
      cyc(1);
      wr_status(32'h4);
      rd_status("t2_ovr_cleared");
      cyc(2);

      // Framing error, then a good frame
      send_frame(8'h3C, 1'b0);
      rd_status("t3_frame_err");
      send_frame(8'h7E, 1'b1);
      rd_data("t3_data_7e");
      cyc(1);
      wr_status(32'h8);
      rd_status("t3_fe_cleared");
      cyc(2);

      // Short low glitch on idle line
      rx = 1'b0;
      cyc(4);
      rx = 1'b1;
      cyc(40);
      rd_status("t4_glitch_status");
      cyc(2);

      // Interrupt enabled
      wr_ctrl(2'b11);
      send_frame(8'h55, 1'b1);
      probe("t5_irq_on", 0, 32'h1);
      rd_data("t5_data_55");
      cyc(1);
      probe("t5_irq_off", 0, 32'h0);
      rd_data("t5_empty_read");
      cyc(2);
      wr_ctrl(2'b01);

      // Receiver disabled mid-frame drops the partial byte
      rx = 1'b0;
      cyc(16);
      rx = 1'b1;
      cyc(48);
      wr_ctrl(2'b00);
      wr_ctrl(2'b01);
      cyc(200);
      rd_status("t6_abort_status");
      cyc(2);

      // Receiver disabled for a whole frame
      wr_ctrl(2'b00);
      send_frame(8'h5A, 1'b1);
      wr_ctrl(2'b01);
      rd_status("t7_disabled_status");
      cyc(2);

      // Randomised traffic across prescale settings
      for (int it = 0; it < 20; it++) begin
         wr_pre(16'($urandom_range(0, 2)));
         for (int f = 0; f < int'($urandom_range(1, 2)); f++) begin
            d = 8'($urandom);
            send_frame(d, ($urandom_range(0, 7) != 0));
         end
         for (int r = 0; r < int'($urandom_range(0, 5)); r++) begin
            if ($urandom_range(0, 2) == 0) rd_status("rnd_status");
            else                           rd_data("rnd_data");
         end
         cyc(1);
         if ($urandom_range(0, 3) == 0) wr_status($urandom & 32'hC);
         rd_status("rnd_status_end");
         cyc(2);
      end

      // Reset in the middle of a frame with irq pending
      while (m_fifo.size() > 0) rd_data("t8_flush");
      cyc(1);
      wr_pre(16'd1);
      wr_ctrl(2'b11);
      send_frame(8'h99, 1'b1);
      probe("t8_irq_before_rst", 0, 32'h1);
      cyc(1);
      rx = 1'b0;
      cyc(20);
      HRESETn = 1'b0;
      model_reset();
      probe("t8_irq_in_rst", 0, 32'h0);
      probe("t8_hrdata_in_rst", 1, 32'h0);
      cyc(1);
      rx = 1'b1;
      cyc(3);
      HRESETn = 1'b1;
      cyc(2);
      rd_status("t8_status_after_rst");
      rd(4'h8, 32'(PRE_RST), "t8_prescale_after_rst");
      rd(4'hC, 32'h1, "t8_ctrl_after_rst");
      cyc(1);
      send_frame(8'hC3, 1'b1);
      rd_status("t8_status_c3");
      rd_data("t8_data_c3");
      cyc(4);

      if (rd_q.size() != 0 || pr_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL pending_checks: got %0d reads and %0d probes outstanding, required 0",
                  rd_q.size(), pr_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
